// File: rtl/command_response_router.sv
// Tag allocator and response return path for the AFU command interface.
// Hands out the lowest free tag per issue, records its owner, and routes PSL responses back.
`timescale 1ns/1ps
module command_response_router #(
    parameter int unsigned NUM_REQUESTS = 4,
    parameter int unsigned TAG_DEPTH    = 32,
    localparam int unsigned TAG_WIDTH   = $clog2(TAG_DEPTH),
    localparam int unsigned REQ_WIDTH   = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1,
    localparam int unsigned COUNT_WIDTH = TAG_WIDTH + 1
) (
    input  logic                    clock,
    input  logic                    rstn,
    input  logic                    enabled_in,
    input  logic                    issue_valid,
    input  logic [REQ_WIDTH-1:0]    issue_requester,
    output logic                    tag_available,
    output logic [TAG_WIDTH-1:0]    issue_tag,
    input  logic                    response_valid,
    input  logic [7:0]              response_tag,
    input  logic [7:0]              response_code,
    output logic [NUM_REQUESTS-1:0] response_out_valid,
    output logic [TAG_WIDTH-1:0]    response_out_tag,
    output logic [7:0]              response_out_code,
    output logic [COUNT_WIDTH-1:0]  outstanding_count,
    output logic                    unexpected_response,
    output logic                    issue_overflow
);

    logic                 enabled;
    logic [TAG_DEPTH-1:0] busy;
    logic [REQ_WIDTH-1:0] owner [TAG_DEPTH];
    logic                 any_free;
    logic                 accept;
    logic                 s1_valid;
    logic [TAG_WIDTH-1:0] s1_tag;
    logic [7:0]           s1_code;
    logic                 s2_hit;
    logic [TAG_DEPTH-1:0] set_mask;
    logic [TAG_DEPTH-1:0] clear_mask;

    generate
        if (TAG_WIDTH < 8) begin : g_unused_tag
            logic unused_tag_bits;
            assign unused_tag_bits = ^response_tag[7:TAG_WIDTH];
        end
    endgenerate

    // Lowest-index free tag; scanning downward leaves the smallest index last.
    always_comb begin
        issue_tag = '0;
        any_free  = 1'b0;
        for (int i = TAG_DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                issue_tag = TAG_WIDTH'(i);
                any_free  = 1'b1;
            end
        end
    end

    assign tag_available = enabled && any_free;
    assign accept        = issue_valid && tag_available;
    assign s2_hit        = s1_valid && busy[s1_tag];
    assign set_mask      = accept ? (TAG_DEPTH'(1) << issue_tag) : '0;
    assign clear_mask    = s2_hit ? (TAG_DEPTH'(1) << s1_tag) : '0;

    // Tag state, count and sticky flags; an issue never targets the tag being freed.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            enabled             <= 1'b0;
            busy                <= '0;
            outstanding_count   <= '0;
            unexpected_response <= 1'b0;
            issue_overflow      <= 1'b0;
            for (int i = 0; i < TAG_DEPTH; i++) begin
                owner[i] <= '0;
            end
        end else begin
            enabled           <= enabled_in;
            busy              <= (busy | set_mask) & ~clear_mask;
            outstanding_count <= outstanding_count + COUNT_WIDTH'(accept) - COUNT_WIDTH'(s2_hit);
            if (accept) begin
                owner[issue_tag] <= issue_requester;
            end
            if (issue_valid && !tag_available) begin
                issue_overflow <= 1'b1;
            end
            if (s1_valid && !busy[s1_tag]) begin
                unexpected_response <= 1'b1;
            end
        end
    end

    // Two-stage response pipeline: capture, then look up owner and strobe.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            s1_valid           <= 1'b0;
            s1_tag             <= '0;
            s1_code            <= '0;
            response_out_valid <= '0;
            response_out_tag   <= '0;
            response_out_code  <= '0;
        end else begin
            s1_valid           <= response_valid;
            s1_tag             <= response_tag[TAG_WIDTH-1:0];
            s1_code            <= response_code;
            response_out_valid <= s2_hit ? (NUM_REQUESTS'(1) << owner[s1_tag]) : '0;
            if (s2_hit) begin
                response_out_tag  <= s1_tag;
                response_out_code <= s1_code;
            end
        end
    end

endmodule

// File: tb/tb_command_response_router.sv
// Directed plus randomized bench for command_response_router against a tag-table reference model.
`timescale 1ns/1ps
module tb_command_response_router;

    logic       clock = 1'b0;
    logic       rstn;
    logic       enabled_in;
    logic       issue_valid;
    logic [1:0] issue_requester;
    logic       tag_available;
    logic [4:0] issue_tag;
    logic       response_valid;
    logic [7:0] response_tag;
    logic [7:0] response_code;
    logic [3:0] response_out_valid;
    logic [4:0] response_out_tag;
    logic [7:0] response_out_code;
    logic [5:0] outstanding_count;
    logic       unexpected_response;
    logic       issue_overflow;

    command_response_router dut (
        .clock(clock), .rstn(rstn), .enabled_in(enabled_in),
        .issue_valid(issue_valid), .issue_requester(issue_requester),
        .tag_available(tag_available), .issue_tag(issue_tag),
        .response_valid(response_valid), .response_tag(response_tag),
        .response_code(response_code), .response_out_valid(response_out_valid),
        .response_out_tag(response_out_tag), .response_out_code(response_out_code),
        .outstanding_count(outstanding_count),
        .unexpected_response(unexpected_response), .issue_overflow(issue_overflow)
    );

    always #5 clock = ~clock;

    typedef struct { int due; int tag; int code; } resp_t;

    bit    busy_m [32];
    int    owner_m [32];
    int    count_m;
    bit    en_m, unexp_m, ovf_m;
    int    outv_m, outtag_m, outcode_m;
    resp_t pend [$];
    int    cyc_n;
    int    passed = 0;
    int    total  = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < 32; i++) if (!busy_m[i]) return i;
        return 0;
    endfunction

    function automatic bit any_free();
        for (int i = 0; i < 32; i++) if (!busy_m[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) begin busy_m[i] = 0; owner_m[i] = 0; end
        count_m = 0; en_m = 0; unexp_m = 0; ovf_m = 0;
        outv_m = 0; outtag_m = 0; outcode_m = 0;
        pend.delete();
        cyc_n = 0;
    endfunction

    task automatic check_all();
        chk("tag_available", 32'(tag_available), 32'(en_m && any_free()));
        chk("issue_tag", 32'(issue_tag), 32'(lowest_free()));
        chk("outstanding_count", 32'(outstanding_count), 32'(count_m));
        chk("response_out_valid", 32'(response_out_valid), 32'(outv_m));
        if (outv_m != 0) begin
            chk("response_out_tag", 32'(response_out_tag), 32'(outtag_m));
            chk("response_out_code", 32'(response_out_code), 32'(outcode_m));
        end
        chk("unexpected_response", 32'(unexpected_response), 32'(unexp_m));
        chk("issue_overflow", 32'(issue_overflow), 32'(ovf_m));
    endtask

    // One clock: drive inputs, update the model at the edge, compare on the falling edge.
    task automatic step(input bit iv, input int req, input bit rv, input int tag, input int code);
        resp_t r;
        bit    avail;
        int    t;
        issue_valid     = iv;
        issue_requester = 2'(req);
        response_valid  = rv;
        response_tag    = 8'(tag);
        response_code   = 8'(code);
        @(posedge clock);
        cyc_n++;
        avail  = en_m && any_free();
        t      = lowest_free();
        outv_m = 0;
        if (pend.size() > 0 && pend[0].due == cyc_n) begin
            r = pend.pop_front();
            if (busy_m[r.tag]) begin
                outv_m    = 1 << owner_m[r.tag];
                outtag_m  = r.tag;
                outcode_m = r.code;
                busy_m[r.tag] = 0;
                count_m--;
            end else begin
                unexp_m = 1;
            end
        end
        if (rv) pend.push_back('{cyc_n + 1, tag % 32, code % 256});
        if (iv) begin
            if (avail) begin
                busy_m[t] = 1; owner_m[t] = req; count_m++;
            end else begin
                ovf_m = 1;
            end
        end
        en_m = enabled_in;
        @(negedge clock);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_list [$];
        rstn = 1'b0; enabled_in = 1'b0; issue_valid = 1'b0; issue_requester = '0;
        response_valid = 1'b0; response_tag = '0; response_code = '0;
        model_reset();
        repeat (3) @(negedge clock);
        chk("rst_tag_available", 32'(tag_available), 0);
        chk("rst_issue_tag", 32'(issue_tag), 0);
        chk("rst_count", 32'(outstanding_count), 0);
        chk("rst_out_valid", 32'(response_out_valid), 0);
        chk("rst_out_tag", 32'(response_out_tag), 0);
        chk("rst_out_code", 32'(response_out_code), 0);
        chk("rst_flags", 32'({unexpected_response, issue_overflow}), 0);
        rstn = 1'b1;

        // Enable takes one register stage
        enabled_in = 1'b1;
        #1 chk("en_before_edge", 32'(tag_available), 0);
        idle(1);
        chk("en_tag_available", 32'(tag_available), 1);

        // Basic round trip to requester 2
        step(1, 2, 0, 0, 0);
        step(0, 0, 1, 0, 8'h00);
        chk("rt_no_early_strobe", 32'(response_out_valid), 0);
        idle(1);
        chk("rt_strobe", 32'(response_out_valid), 32'h4);
        chk("rt_count", 32'(outstanding_count), 0);
        idle(1);
        chk("rt_single_pulse", 32'(response_out_valid), 0);

        // Out-of-order return
        for (int i = 0; i < 4; i++) step(1, i, 0, 0, 0);
        step(0, 0, 1, 3, 8'h13);
        step(0, 0, 1, 0, 8'h10);
        chk("ooo_first", 32'(response_out_valid), 32'h8);
        step(0, 0, 1, 2, 8'h12);
        chk("ooo_second", 32'(response_out_valid), 32'h1);
        step(0, 0, 1, 1, 8'h11);
        chk("ooo_third", 32'(response_out_valid), 32'h4);
        idle(1);
        chk("ooo_fourth", 32'(response_out_valid), 32'h2);
        idle(1);

        // Spurious response, upper tag bits ignored
        step(0, 0, 1, 8'hE5, 8'h55);
        idle(1);
        chk("spur_flag", 32'(unexpected_response), 1);
        chk("spur_no_strobe", 32'(response_out_valid), 0);

        // Issue and free in the same edge
        step(1, 1, 0, 0, 0);
        step(1, 3, 0, 0, 0);
        step(0, 0, 1, 0, 8'h66);
        chk("sim_offer", 32'(issue_tag), 2);
        step(1, 2, 0, 0, 0);
        chk("sim_count", 32'(outstanding_count), 2);
        chk("sim_reoffer", 32'(issue_tag), 0);
        step(0, 0, 1, 1, 8'h01);
        step(0, 0, 1, 2, 8'h02);
        idle(2);

        // Exhaustion and overflow
        for (int i = 0; i < 32; i++) begin
            chk("exh_tag", 32'(issue_tag), 32'(i));
            step(1, int'($urandom_range(0, 3)), 0, 0, 0);
        end
        chk("exh_count", 32'(outstanding_count), 32);
        chk("exh_unavailable", 32'(tag_available), 0);
        step(1, 0, 0, 0, 0);
        chk("exh_overflow", 32'(issue_overflow), 1);
        for (int i = 0; i < 32; i++) step(0, 0, 1, 31 - i, i);
        idle(2);
        chk("exh_drained", 32'(outstanding_count), 0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            int tag;
            if ($urandom_range(0, 40) == 0) enabled_in = ~enabled_in;
            busy_list.delete();
            for (int i = 0; i < 32; i++) if (busy_m[i]) busy_list.push_back(i);
            if (busy_list.size() > 0 && $urandom_range(0, 7) != 0)
                tag = busy_list[$urandom_range(0, busy_list.size() - 1)] + 32 * int'($urandom_range(0, 7));
            else
                tag = int'($urandom_range(0, 255));
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 2) != 0), tag, int'($urandom_range(0, 255)));
        end

        // Reset mid-operation with a response in flight
        enabled_in = 1'b1;
        idle(1);
        step(1, 1, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        step(0, 0, 1, lowest_free() == 0 ? 0 : 0, 8'h77);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_count", 32'(outstanding_count), 0);
        chk("mid_rst_available", 32'(tag_available), 0);
        chk("mid_rst_issue_tag", 32'(issue_tag), 0);
        chk("mid_rst_out_valid", 32'(response_out_valid), 0);
        chk("mid_rst_flags", 32'({unexpected_response, issue_overflow}), 0);
        @(negedge clock);
        model_reset();
        rstn = 1'b1;
        idle(3);
        chk("post_rst_available", 32'(tag_available), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
